// File: rtl/bit_index_scanner_pkg.sv
// -----------------------------------------------------------------------------
// bitscan_pkg
// Shared definitions for the bit index scanner slice.
//   DEFAULT_SIZE / DEFAULT_BID_W : default batch width and sequence-tag width
//   MAX_SIZE                     : widest batch the popcount helper accepts
//   bid_t                        : sequence tag type at the default tag width
//   onehot_or_zero()             : true when at most one bit of v is set
// -----------------------------------------------------------------------------
package bitscan_pkg;

    localparam int DEFAULT_SIZE  = 64;
    localparam int DEFAULT_BID_W = 4;
    localparam int MAX_SIZE      = 1024;

    typedef logic [DEFAULT_BID_W-1:0] bid_t;

    // Popcount <= 1: clearing the lowest set bit leaves nothing behind.
    function automatic logic onehot_or_zero(input logic [MAX_SIZE-1:0] v);
        logic [MAX_SIZE-1:0] one_s;
        one_s = {{(MAX_SIZE-1){1'b0}}, 1'b1};
        return ((v & (v - one_s)) == {MAX_SIZE{1'b0}});
    endfunction

endpackage

// File: rtl/bit_index_scanner_encoder.sv
// -----------------------------------------------------------------------------
// bit_priority_encoder
// Purely combinational priority encoder over a SIZE-bit vector.
//   vec   : input bitmap
//   index : position of the lowest set bit (highest when BITSCAN_MSB_FIRST_EN
//           is defined); zero when vec is all zero
//   any   : at least one bit of vec is set
// Optional macro: BITSCAN_MSB_FIRST_EN selects highest-bit-first priority.
// -----------------------------------------------------------------------------
module bit_priority_encoder #(
    parameter int SIZE     = 64,
    parameter int LOG_SIZE = $clog2(SIZE)
) (
    input  logic [SIZE-1:0]     vec,
    output logic [LOG_SIZE-1:0] index,
    output logic                any
);

    // Priority scan: the bit visited last among the set bits wins, so the
    // loop direction decides which end of the vector has priority.
    always_comb begin
        index = {LOG_SIZE{1'b0}};
        any   = |vec;
`ifdef BITSCAN_MSB_FIRST_EN
        for (int i = 0; i < SIZE; i++) begin
            index = vec[i] ? i[LOG_SIZE-1:0] : index;
        end
`else
        for (int i = SIZE - 1; i >= 0; i--) begin
            index = vec[i] ? i[LOG_SIZE-1:0] : index;
        end
`endif
    end

endmodule

// File: rtl/bit_index_scanner.sv
// -----------------------------------------------------------------------------
// bit_index_scanner
// Accepts a SIZE-bit batch over a valid/ready handshake, then emits the index
// of every set bit, one per cycle, over a second valid/ready handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : synchronous discard of the held batch (tag unchanged)
//   batch_valid  : source offers batch_data
//   batch_data   : batch bitmap
//   batch_ready  : block can take a batch this cycle
//   idx_valid    : idx is valid
//   idx          : position of the current selected remaining set bit
//   idx_last     : idx is the final remaining set bit
//   idx_bid      : sequence tag of the batch idx belongs to
//   idx_ready    : consumer accepts idx
// Optional macro: BITSCAN_MSB_FIRST_EN emits indices highest first.
// -----------------------------------------------------------------------------
module bit_index_scanner
    import bitscan_pkg::*;
#(
    parameter  int SIZE     = DEFAULT_SIZE,
    parameter  int BID_W    = DEFAULT_BID_W,
    localparam int LOG_SIZE = $clog2(SIZE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                batch_valid,
    input  logic [SIZE-1:0]     batch_data,
    output logic                batch_ready,
    output logic                idx_valid,
    output logic [LOG_SIZE-1:0] idx,
    output logic                idx_last,
    output logic [BID_W-1:0]    idx_bid,
    input  logic                idx_ready
);

    localparam logic [SIZE-1:0]  BIT_ONE = SIZE'(1'b1);
    localparam logic [BID_W-1:0] BID_ONE = BID_W'(1'b1);

    logic [SIZE-1:0]     rem_r;
    logic [BID_W-1:0]    bid_r;
    logic [LOG_SIZE-1:0] enc_idx_s;
    logic                enc_any_s;
    logic                accept_s;
    logic                load_s;

    bit_priority_encoder #(
        .SIZE     (SIZE),
        .LOG_SIZE (LOG_SIZE)
    ) u_enc (
        .vec   (rem_r),
        .index (enc_idx_s),
        .any   (enc_any_s)
    );

    // Handshake decode; a last-index accept reopens batch_ready in the same
    // cycle so consecutive batches stream without a bubble.
    always_comb begin
        idx_valid   = enc_any_s;
        idx         = enc_idx_s;
        idx_last    = enc_any_s && onehot_or_zero(MAX_SIZE'(rem_r));
        idx_bid     = enc_any_s ? (bid_r - BID_ONE) : {BID_W{1'b0}};
        accept_s    = idx_valid && idx_ready;
        batch_ready = !flush && (!enc_any_s || (accept_s && idx_last));
        load_s      = batch_valid && batch_ready;
    end

    // Remaining-bits and tag state: flush beats load, load beats accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r <= {SIZE{1'b0}};
            bid_r <= {BID_W{1'b0}};
        end else if (flush) begin
            rem_r <= {SIZE{1'b0}};
        end else if (load_s) begin
            rem_r <= batch_data;
            bid_r <= bid_r + BID_ONE;
        end else if (accept_s) begin
            rem_r <= rem_r & ~(BIT_ONE << enc_idx_s);
        end else begin
            rem_r <= rem_r;
        end
    end

endmodule

// File: tb/tb_bit_index_scanner.sv
module tb_bit_index_scanner;

    localparam int SIZE = 8;
    localparam int LS   = 3;
    localparam int BW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, batch_valid, idx_ready;
    logic [7:0]    batch_data;
    logic          batch_ready, idx_valid, idx_last;
    logic [LS-1:0] idx;
    logic [BW-1:0] idx_bid;

    logic          flush64, batch_valid64, idx_ready64;
    logic [63:0]   batch_data64;
    logic          batch_ready64, idx_valid64, idx_last64;
    logic [5:0]    idx64;
    logic [BW-1:0] idx_bid64;

    int n_cmp = 0;
    int n_err = 0;
    int bid_m = 0;
    int q[$];

    always #5 clk = ~clk;

    bit_index_scanner #(.SIZE(SIZE), .BID_W(BW)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .batch_valid(batch_valid),
        .batch_data(batch_data), .batch_ready(batch_ready), .idx_valid(idx_valid),
        .idx(idx), .idx_last(idx_last), .idx_bid(idx_bid), .idx_ready(idx_ready)
    );

    bit_index_scanner #(.SIZE(64), .BID_W(BW)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64), .batch_valid(batch_valid64),
        .batch_data(batch_data64), .batch_ready(batch_ready64), .idx_valid(idx_valid64),
        .idx(idx64), .idx_last(idx_last64), .idx_bid(idx_bid64), .idx_ready(idx_ready64)
    );

    wire [9:0] obs = {idx_valid, idx, idx_last, idx_bid, batch_ready};

    function automatic logic [9:0] ev(input logic v, input logic [2:0] i, input logic l,
                                      input logic [3:0] b, input logic r);
        return {v, i, l, b, r};
    endfunction

    function automatic logic [3:0] cur_tag();
        logic [3:0] t;
        t = bid_m[3:0] - 4'd1;
        return t;
    endfunction

    // Reference: the batch becomes an ordered list of set-bit positions.
    function automatic void load_q(input logic [7:0] b);
        q.delete();
        for (int i = 0; i < SIZE; i++) begin
            if (b[i]) begin
`ifdef BITSCAN_MSB_FIRST_EN
                q.push_front(i);
`else
                q.push_back(i);
`endif
            end
        end
    endfunction

    task automatic drive(input logic bv, input logic [7:0] bd, input logic ir, input logic fl);
        batch_valid = bv; batch_data = bd; idx_ready = ir; flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush64 = 1'b0; batch_valid64 = 1'b0; batch_data64 = 64'd0; idx_ready64 = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== ev(1'b0, 3'd0, 1'b0, 4'd0, 1'b1)) begin
            n_err++; $display("FAIL reset got %h exp %h", obs, ev(1'b0, 3'd0, 1'b0, 4'd0, 1'b1));
        end
        tick(); tick();
        rst_n = 1'b1;
        bid_m = 0;
        tick();
    endtask

    task automatic test_basic_scan();
        logic [2:0] e[3];
`ifdef BITSCAN_MSB_FIRST_EN
        e = '{3'd7, 3'd5, 3'd2};
`else
        e = '{3'd2, 3'd5, 3'd7};
`endif
        drive(1'b1, 8'hA4, 1'b1, 1'b0);
        tick(); bid_m++;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (obs !== ev(1'b1, e[k], k == 2, 4'd0, k == 2)) begin
                n_err++; $display("FAIL basic_scan_%0d got %h exp %h", k, obs, ev(1'b1, e[k], k == 2, 4'd0, k == 2));
            end
            tick();
        end
        n_cmp++;
        if (obs !== ev(1'b0, 3'd0, 1'b0, 4'd0, 1'b1)) begin
            n_err++; $display("FAIL basic_scan_end got %h", obs);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 8'h80, 1'b1, 1'b0);
        tick(); bid_m++;
        drive(1'b1, 8'h01, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== ev(1'b1, 3'd7, 1'b1, cur_tag(), 1'b1)) begin
            n_err++; $display("FAIL b2b_first got %h exp %h", obs, ev(1'b1, 3'd7, 1'b1, cur_tag(), 1'b1));
        end
        tick(); bid_m++;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== ev(1'b1, 3'd0, 1'b1, cur_tag(), 1'b1)) begin
            n_err++; $display("FAIL b2b_second got %h exp %h", obs, ev(1'b1, 3'd0, 1'b1, cur_tag(), 1'b1));
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [2:0] a, b;
`ifdef BITSCAN_MSB_FIRST_EN
        a = 3'd3; b = 3'd2;
`else
        a = 3'd2; b = 3'd3;
`endif
        drive(1'b1, 8'h0C, 1'b0, 1'b0);
        tick(); bid_m++;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (obs !== ev(1'b1, a, 1'b0, cur_tag(), 1'b0)) begin
                n_err++; $display("FAIL bp_hold_%0d got %h exp %h", k, obs, ev(1'b1, a, 1'b0, cur_tag(), 1'b0));
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== ev(1'b1, a, 1'b0, cur_tag(), 1'b0)) begin
            n_err++; $display("FAIL bp_first got %h", obs);
        end
        tick();
        n_cmp++;
        if (obs !== ev(1'b1, b, 1'b1, cur_tag(), 1'b1)) begin
            n_err++; $display("FAIL bp_second got %h exp %h", obs, ev(1'b1, b, 1'b1, cur_tag(), 1'b1));
        end
        tick();
    endtask

    task automatic test_zero_wrap();
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 8'h00, 1'b1, 1'b0);
            n_cmp++;
            if (obs !== ev(1'b0, 3'd0, 1'b0, 4'd0, 1'b1)) begin
                n_err++; $display("FAIL zero_%0d got %h", k, obs);
            end
            tick(); bid_m++;
        end
        drive(1'b1, 8'h10, 1'b1, 1'b0);
        tick(); bid_m++;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== ev(1'b1, 3'd4, 1'b1, cur_tag(), 1'b1)) begin
            n_err++; $display("FAIL zero_wrap_tag got %h exp %h", obs, ev(1'b1, 3'd4, 1'b1, cur_tag(), 1'b1));
        end
        tick();
    endtask

    task automatic test_flush_reset();
        logic [2:0] s0, s1, s2;
`ifdef BITSCAN_MSB_FIRST_EN
        s0 = 3'd7; s1 = 3'd6; s2 = 3'd5;
`else
        s0 = 3'd0; s1 = 3'd1; s2 = 3'd2;
`endif
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        tick(); bid_m++;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== ev(1'b1, s0, 1'b0, cur_tag(), 1'b0)) begin
            n_err++; $display("FAIL flush_pre got %h", obs);
        end
        tick(); tick();
        drive(1'b1, 8'h55, 1'b1, 1'b1);
        n_cmp++;
        if (obs !== ev(1'b1, s2, 1'b0, cur_tag(), 1'b0)) begin
            n_err++; $display("FAIL flush_cycle got %h exp %h", obs, ev(1'b1, s2, 1'b0, cur_tag(), 1'b0));
        end
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== ev(1'b0, 3'd0, 1'b0, 4'd0, 1'b1)) begin
            n_err++; $display("FAIL flush_after got %h", obs);
        end
        drive(1'b1, 8'h02, 1'b1, 1'b0);
        tick(); bid_m++;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== ev(1'b1, 3'd1, 1'b1, cur_tag(), 1'b1)) begin
            n_err++; $display("FAIL flush_tag got %h exp %h", obs, ev(1'b1, 3'd1, 1'b1, cur_tag(), 1'b1));
        end
        tick();
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        tick(); bid_m++;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if (obs !== ev(1'b1, s1, 1'b0, cur_tag(), 1'b0)) begin
            n_err++; $display("FAIL rst_pre got %h", obs);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== ev(1'b0, 3'd0, 1'b0, 4'd0, 1'b1)) begin
            n_err++; $display("FAIL rst_async got %h", obs);
        end
        tick();
        rst_n = 1'b1;
        bid_m = 0;
        tick();
        n_cmp++;
        if (obs !== ev(1'b0, 3'd0, 1'b0, 4'd0, 1'b1)) begin
            n_err++; $display("FAIL rst_after got %h", obs);
        end
    endtask

    task automatic test_wide_ends();
        logic [5:0] a, b;
`ifdef BITSCAN_MSB_FIRST_EN
        a = 6'd63; b = 6'd0;
`else
        a = 6'd0; b = 6'd63;
`endif
        batch_valid64 = 1'b1; batch_data64 = {1'b1, 62'd0, 1'b1}; idx_ready64 = 1'b1;
        tick();
        batch_valid64 = 1'b0;
        #1;
        n_cmp++;
        if ({idx_valid64, idx64, idx_last64, idx_bid64} !== {1'b1, a, 1'b0, 4'd0}) begin
            n_err++; $display("FAIL wide_first got v=%b i=%0d l=%b exp i=%0d", idx_valid64, idx64, idx_last64, a);
        end
        tick();
        n_cmp++;
        if ({idx_valid64, idx64, idx_last64, batch_ready64} !== {1'b1, b, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL wide_last got v=%b i=%0d l=%b exp i=%0d", idx_valid64, idx64, idx_last64, b);
        end
        tick();
        n_cmp++;
        if (idx_valid64 !== 1'b0) begin
            n_err++; $display("FAIL wide_end got v=%b exp 0", idx_valid64);
        end
    endtask

    task automatic test_random();
        logic       bv, ir, fl, ev_v, ev_l, ev_r;
        logic [7:0] bd;
        logic [2:0] ev_i;
        logic [3:0] ev_b;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            bv = ($urandom_range(0, 2) != 0);
            bd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            ir = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 29) == 0);
            drive(bv, bd, ir, fl);
            ev_v = (q.size() != 0);
            ev_i = ev_v ? 3'(q[0]) : 3'd0;
            ev_l = (q.size() == 1);
            ev_b = ev_v ? cur_tag() : 4'd0;
            ev_r = !fl && (!ev_v || (ir && ev_l));
            n_cmp++;
            if (obs !== ev(ev_v, ev_i, ev_l, ev_b, ev_r)) begin
                n_err++; $display("FAIL rand_%0d got %h exp %h", c, obs, ev(ev_v, ev_i, ev_l, ev_b, ev_r));
            end
            if (fl) q.delete();
            else if (bv && ev_r) begin load_q(bd); bid_m++; end
            else if (ev_v && ir) void'(q.pop_front());
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_back_to_back();
        test_backpressure();
        test_zero_wrap();
        test_flush_reset();
        test_wide_ends();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
